// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a mem_ready
// handshake, optional memory timeout, illegal-opcode trapping and a retired-instruction counter.
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT  = 16,
    parameter int ILLEGAL_TRAP = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic [3:0]       state,
    output logic             fault,
    output logic [1:0]       fault_cause,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_I_EXEC    = 4'd9,
        S_I_WB      = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12,
        S_FAULT     = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // The wait counter only has to reach MEM_TIMEOUT-1: that cycle decides between ready and fault.
    localparam int                WAIT_W   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    state_t             r_state;
    state_t             w_next;
    logic [5:0]         r_op;
    logic [WAIT_W-1:0]  r_wait;
    logic [1:0]         r_cause;
    logic [1:0]         w_next_cause;
    logic [CNT_W-1:0]   r_retired;
    logic               w_waiting;
    logic               w_timeout;
    logic               w_retire;

    assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEM_READ) || (r_state == S_MEM_WRITE);
    assign w_timeout = (MEM_TIMEOUT != 0) && !mem_ready && (r_wait == WAIT_LIM);
    assign w_retire  = (w_next == S_FETCH) &&
                       ((r_state == S_MEM_WB) || (r_state == S_MEM_WRITE) || (r_state == S_R_WB) ||
                        (r_state == S_I_WB)   || (r_state == S_BRANCH)    || (r_state == S_JUMP));

    // State, latched opcode, wait counter, fault cause and retired counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_op      <= 6'b000000;
            r_wait    <= '0;
            r_cause   <= CAUSE_NONE;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            r_cause <= w_next_cause;
            if (r_state == S_DECODE) begin
                r_op <= opcode;
            end
            if (w_next != r_state) begin
                r_wait <= '0;
            end else if (w_waiting && !mem_ready) begin
                r_wait <= r_wait + WAIT_ONE;
            end
            if (w_retire) begin
                r_retired <= r_retired + CNT_ONE;
            end
        end
    end

    // Next-state and fault-cause selection.
    always_comb begin
        w_next       = r_state;
        w_next_cause = r_cause;
        case (r_state)
            S_IDLE:     w_next = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    w_next = S_DECODE;
                end else if (w_timeout) begin
                    w_next       = S_FAULT;
                    w_next_cause = CAUSE_TIMEOUT;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:                                      w_next = S_R_EXEC;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI:    w_next = S_I_EXEC;
                    OP_LW, OP_SW:                                  w_next = S_MEM_ADDR;
                    OP_BEQ:                                        w_next = S_BRANCH;
                    OP_J:                                          w_next = S_JUMP;
                    default: begin
                        if (ILLEGAL_TRAP != 0) begin
                            w_next       = S_FAULT;
                            w_next_cause = CAUSE_ILLEGAL;
                        end else begin
                            w_next = S_FETCH;
                        end
                    end
                endcase
            end
            S_MEM_ADDR: begin
                if (r_op == OP_SW) begin
                    w_next = S_MEM_WRITE;
                end else begin
                    w_next = S_MEM_READ;
                end
            end
            S_MEM_READ, S_MEM_WRITE: begin
                if (mem_ready) begin
                    w_next = (r_state == S_MEM_READ) ? S_MEM_WB : S_FETCH;
                end else if (w_timeout) begin
                    w_next       = S_FAULT;
                    w_next_cause = CAUSE_TIMEOUT;
                end else begin
                    w_next = r_state;
                end
            end
            S_MEM_WB:   w_next = S_FETCH;
            S_R_EXEC:   w_next = S_R_WB;
            S_R_WB:     w_next = S_FETCH;
            S_I_EXEC:   w_next = S_I_WB;
            S_I_WB:     w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            S_JUMP:     w_next = S_FETCH;
            S_FAULT:    w_next = S_FAULT;
            default: begin
                w_next       = S_FAULT;
                w_next_cause = CAUSE_NONE;
            end
        endcase
    end

    // Control decode from the current state; FETCH strobes IR/PC as soon as memory is ready.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 3'b000;
        pc_src        = 2'b00;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE:   alu_src_b = 2'b11;
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b010;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (r_op)
                    OP_SLTI:                   alu_op = 3'b001;
                    OP_ANDI, OP_ORI, OP_XORI:  alu_op = 3'b011;
                    default:                   alu_op = 3'b000;
                endcase
            end
            S_I_WB:     reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 3'b100;
                pc_write_cond = 1'b1;
                pc_src        = 2'b01;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
            end
            default: begin
                pc_write = 1'b0;
            end
        endcase
    end

    assign state       = r_state;
    assign fault       = (r_state == S_FAULT);
    assign fault_cause = r_cause;
    assign retired     = r_retired;

endmodule
